// File: rtl/nn_harness_pkg.sv
// Shared types and helpers for the on-chip classifier test harness.
package nn_harness_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_LABEL,
    S_STREAM,
    S_WAIT_RESULT,
    S_COMPARE,
    S_DONE
  } state_t;

  // Each frame occupies frame_len samples followed by its label word.
  function automatic logic [31:0] frame_word_addr(input logic [31:0] frame,
                                                  input logic [31:0] word,
                                                  input logic [31:0] frame_len);
    return frame * (frame_len + 32'd1) + word;
  endfunction

endpackage

// File: rtl/nn_prefetch_fifo.sv
// Two-entry prefetch FIFO; the head entry is a register driving the stream output directly.
module nn_prefetch_fifo #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= push_data;
          else                   tail_reg <= push_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_reg <= push_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = head_reg;
  assign count     = count_reg;
  assign empty     = (count_reg == 2'd0);
  assign full      = (count_reg == 2'd2);

endmodule

// File: rtl/nn_test_harness.sv
// Streams stored frames into the classifier, checks each result against its label
// and keeps frame/correct counters for in-system accuracy measurement.
module nn_test_harness
  import nn_harness_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FRAME_LEN      = 784,
  parameter int NUM_FRAMES     = 1000,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int ADDR_WIDTH     = $clog2(NUM_FRAMES*(FRAME_LEN+1))
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic                              o_mem_en,
  input  logic [DATA_WIDTH-1:0]             i_mem_data,
  output logic [DATA_WIDTH-1:0]             o_m_axis_data,
  output logic                              o_m_axis_valid,
  output logic                              o_m_axis_last,
  input  logic                              i_m_axis_ready,
  input  logic [RESULT_WIDTH-1:0]           i_s_axis_data,
  input  logic                              i_s_axis_valid,
  output logic                              o_s_axis_ready,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   o_frames_run,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   o_correct,
  output logic [RESULT_WIDTH-1:0]           o_last_detected,
  output logic [DATA_WIDTH-1:0]             o_last_expected,
  output logic                              o_timeout
);

  localparam int BEAT_W = $clog2(FRAME_LEN+1);
  localparam int FRM_W  = $clog2(NUM_FRAMES+1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(FRAME_LEN-1);
  localparam logic [BEAT_W-1:0] BEAT_END   = BEAT_W'(FRAME_LEN);
  localparam logic [FRM_W-1:0]  FRAME_LAST = FRM_W'(NUM_FRAMES-1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYCLES-1);

  state_t                    state_reg, state_next;
  logic [FRM_W-1:0]          frame_reg, frame_next;
  logic                      label_pend_reg, label_pend_next;
  logic [DATA_WIDTH-1:0]     label_reg, label_next;
  logic [BEAT_W-1:0]         issue_reg, issue_next;
  logic [BEAT_W-1:0]         beat_reg, beat_next;
  logic                      rd_valid_reg, rd_valid_next;
  logic                      rd_last_reg, rd_last_next;
  logic [TMR_W-1:0]          timer_reg, timer_next;
  logic                      match_reg, match_next;
  logic [RESULT_WIDTH-1:0]   detected_reg, detected_next;
  logic [FRM_W-1:0]          frames_reg, frames_next;
  logic [FRM_W-1:0]          correct_reg, correct_next;
  logic                      timeout_reg, timeout_next;
  logic                      done_reg, done_next;

  logic                      mem_en;
  logic [31:0]               mem_word;
  logic                      s_ready;
  logic [2:0]                occupancy;
  logic                      fifo_pop;
  logic [DATA_WIDTH:0]       fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [1:0]                fifo_count;

  nn_prefetch_fifo #(
    .WIDTH(DATA_WIDTH+1)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (rd_valid_reg),
    .push_data({rd_last_reg, i_mem_data}),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fifo_pop = !fifo_empty && i_m_axis_ready;

  always_comb begin
    state_next      = state_reg;
    frame_next      = frame_reg;
    label_pend_next = label_pend_reg;
    label_next      = label_reg;
    issue_next      = issue_reg;
    beat_next       = beat_reg;
    rd_valid_next   = 1'b0;
    rd_last_next    = rd_last_reg;
    timer_next      = timer_reg;
    match_next      = match_reg;
    detected_next   = detected_reg;
    frames_next     = frames_reg;
    correct_next    = correct_reg;
    timeout_next    = timeout_reg;
    done_next       = done_reg;
    mem_en          = 1'b0;
    mem_word        = '0;
    s_ready         = 1'b0;
    // Occupancy after this cycle's pop, so a steady stream keeps one read in flight.
    occupancy = 3'(fifo_count) + 3'(rd_valid_reg) - 3'(fifo_pop);

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          frames_next     = '0;
          correct_next    = '0;
          timeout_next    = 1'b0;
          done_next       = 1'b0;
          frame_next      = '0;
          label_pend_next = 1'b0;
          state_next      = S_FETCH_LABEL;
        end
      end
      S_FETCH_LABEL: begin
        if (!label_pend_reg) begin
          mem_en          = 1'b1;
          mem_word        = 32'(FRAME_LEN);
          label_pend_next = 1'b1;
        end else begin
          label_next      = i_mem_data;
          label_pend_next = 1'b0;
          issue_next      = '0;
          beat_next       = '0;
          state_next      = S_STREAM;
        end
      end
      S_STREAM: begin
        if ((issue_reg != BEAT_END) && (occupancy < 3'd2) && !(fifo_full && !fifo_pop)) begin
          mem_en        = 1'b1;
          mem_word      = 32'(issue_reg);
          issue_next    = issue_reg + 1'b1;
          rd_valid_next = 1'b1;
          rd_last_next  = (issue_reg == BEAT_LAST);
        end
        if (fifo_pop) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == BEAT_LAST) begin
            timer_next = '0;
            state_next = S_WAIT_RESULT;
          end
        end
      end
      S_WAIT_RESULT: begin
        s_ready = 1'b1;
        if (i_s_axis_valid) begin
          detected_next = i_s_axis_data;
          match_next    = (i_s_axis_data == RESULT_WIDTH'(label_reg));
          state_next    = S_COMPARE;
        end else if (timer_reg == TMR_LAST) begin
          timeout_next = 1'b1;
          match_next   = 1'b0;
          state_next   = S_COMPARE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_COMPARE: begin
        frames_next = frames_reg + 1'b1;
        if (match_reg) correct_next = correct_reg + 1'b1;
        if (frame_reg == FRAME_LAST) begin
          done_next  = 1'b1;
          state_next = S_DONE;
        end else begin
          frame_next      = frame_reg + 1'b1;
          label_pend_next = 1'b0;
          state_next      = S_FETCH_LABEL;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= S_IDLE;
      frame_reg      <= '0;
      label_pend_reg <= 1'b0;
      label_reg      <= '0;
      issue_reg      <= '0;
      beat_reg       <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      timer_reg      <= '0;
      match_reg      <= 1'b0;
      detected_reg   <= '0;
      frames_reg     <= '0;
      correct_reg    <= '0;
      timeout_reg    <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_reg      <= frame_next;
      label_pend_reg <= label_pend_next;
      label_reg      <= label_next;
      issue_reg      <= issue_next;
      beat_reg       <= beat_next;
      rd_valid_reg   <= rd_valid_next;
      rd_last_reg    <= rd_last_next;
      timer_reg      <= timer_next;
      match_reg      <= match_next;
      detected_reg   <= detected_next;
      frames_reg     <= frames_next;
      correct_reg    <= correct_next;
      timeout_reg    <= timeout_next;
      done_reg       <= done_next;
    end
  end

  assign o_busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign o_done          = done_reg;
  assign o_mem_en        = mem_en;
  assign o_mem_addr      = mem_en ? ADDR_WIDTH'(frame_word_addr(32'(frame_reg), mem_word, 32'(FRAME_LEN))) : '0;
  assign o_m_axis_data   = fifo_head[DATA_WIDTH-1:0];
  assign o_m_axis_last   = fifo_head[DATA_WIDTH];
  assign o_m_axis_valid  = !fifo_empty;
  assign o_s_axis_ready  = s_ready;
  assign o_frames_run    = frames_reg;
  assign o_correct       = correct_reg;
  assign o_last_detected = detected_reg;
  assign o_last_expected = label_reg;
  assign o_timeout       = timeout_reg;

endmodule
